// File: rtl/cmp_seq_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks operand bits MSB-first,
// one bit per clock, and stops at the first differing bit.
module cmp_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [31:0]      y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] IDX_TOP = 5'(WIDTH - 1);
    localparam logic [2:0] RES_EQ  = 3'b001;
    localparam logic [2:0] RES_GT  = 3'b010;
    localparam logic [2:0] RES_LT  = 3'b100;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic               sgn_reg, sgn_next;
    logic [4:0]         idx_reg, idx_next;
    logic [31:0]        y_reg, y_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [WIDTH-1:0]   sel_oh;
    logic               a_bit;
    logic               b_bit;
    logic               bit_diff;
    logic               at_msb;
    logic               idx_zero;
    logic [2:0]         res_diff;

    // One-hot decode of the bit pointer keeps the single-bit select free of
    // out-of-range indexing when WIDTH is narrower than the 5-bit pointer.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign sel_oh[gi] = (idx_reg == 5'(gi));
        end
    endgenerate

    assign a_bit    = |(a_reg & sel_oh);
    assign b_bit    = |(b_reg & sel_oh);
    assign bit_diff = a_bit ^ b_bit;
    assign at_msb   = (idx_reg == IDX_TOP);
    assign idx_zero = (idx_reg == 5'd0);

    // In a signed compare the sign bit carries negative weight, so a set
    // MSB on A means A is the smaller operand.
    always_comb begin
        if (a_bit ^ (sgn_reg & at_msb)) begin
            res_diff = RES_GT;
        end else begin
            res_diff = RES_LT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            idx_reg   <= IDX_TOP;
            y_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sgn_reg   <= sgn_next;
            idx_reg   <= idx_next;
            y_reg     <= y_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sgn_next   = sgn_reg;
        idx_next   = idx_reg;
        y_next     = y_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    sgn_next   = is_signed;
                    idx_next   = IDX_TOP;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort takes priority over a decision in the same cycle.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (bit_diff) begin
                    y_next     = {29'd0, res_diff};
                    state_next = ST_DONE;
                end else if (idx_zero) begin
                    y_next     = {29'd0, RES_EQ};
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg - 5'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so nothing reaches the
    // ports combinationally.
    always_comb begin
        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign y    = y_reg;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: directed scenarios plus random
// operands checked against an arithmetic reference model.
module tb_cmp_seq_ctrl;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          is_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [31:0]   y;

    int checks;
    int errors;
    int txn;

    cmp_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_y(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic ms);
        if (ma == mb) return 32'h1;
        if (ms) return ($signed(ma) > $signed(mb)) ? 32'h2 : 32'h4;
        return (ma > mb) ? 32'h2 : 32'h4;
    endfunction

    // Edges from the start-sampling edge to the decision edge.
    function automatic int model_lat(input logic [W-1:0] ma, input logic [W-1:0] mb);
        logic [W-1:0] x;
        x = ma ^ mb;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) return W - i;
        end
        return W;
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after
    // the edge at which the DUT is back in IDLE.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                           input logic ts, input logic abort_at_start);
        int          n;
        bit          got;
        logic [31:0] ey;
        int          el;
        ey = model_y(ta, tbv, ts);
        el = model_lat(ta, tbv);
        a = ta;
        b = tbv;
        is_signed = ts;
        abort = abort_at_start;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        n = 0;
        got = 0;
        while (!got && n < W + 3) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                got = 1;
            end else begin
                check("busy_in_run", 32'(busy), 32'd1);
                start = 1'($urandom_range(0, 1));
                a = $urandom;
                b = $urandom;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(el));
        check("y_result", y, ey);
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_len", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("y_hold", y, ey);
        txn++;
        $display("txn %0d a=0x%08h b=0x%08h signed=%0d y=0x%08h exp=0x%08h lat=%0d exp_lat=%0d",
                 txn, ta, tbv, ts, y, ey, n, el);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sh;
        checks = 0;
        errors = 0;
        txn = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;

        // Reset held while start toggles
        for (int k = 0; k < 4; k++) begin
            start = ~start;
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            check("rst_y", y, 32'h0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmp(32'h0, 32'h0, 1'b0, 1'b0);
        run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_cmp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_cmp(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        run_cmp(32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0);

        // Abort at RUN edge 10, with an ignored start pulse mid-run
        a = 32'h1;
        b = 32'h2;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy_e0", 32'(busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("abort_busy_run", 32'(busy), 32'd1);
            check("abort_done_run", 32'(done), 32'd0);
            start = (k == 3);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_y", y, 32'h4);
        @(posedge clk); #1;
        check("abort_busy2", 32'(busy), 32'd0);
        check("abort_done2", 32'(done), 32'd0);
        check("abort_y2", y, 32'h4);
        $display("txn abort a=0x00000001 b=0x00000002 busy=%0d done=%0d y=0x%08h", busy, done, y);

        // Abort while idle must not block the start
        run_cmp(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);

        // Random operands sharing a random-length common prefix
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            sh = $urandom_range(0, 32);
            rb = (sh == 32) ? ra : (ra ^ ($urandom >> sh));
            run_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset in the middle of a run
        a = '0;
        b = '0;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check("arst_busy_run", 32'(busy), 32'd1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_y", y, 32'h0);
        check("arst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("arst_busy_hold", 32'(busy), 32'd0);
        rst_n = 1'b1;
        $display("txn arst busy=%0d done=%0d y=0x%08h", busy, done, y);
        run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
